// File: rtl/climate_controller.sv
// Occupancy-gated heat/cool controller with setpoint hysteresis, minimum dwell,
// post-run lockout and a three-step proportional fan.
module climate_controller #(
  parameter int unsigned TEMP_W   = 7,
  parameter int unsigned HYST     = 2,
  parameter int unsigned DWELL    = 8,
  parameter int unsigned OCC_HOLD = 16,
  parameter int unsigned FAN_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TEMP_W-1:0] temperature,
  input  logic              humanDetector,
  input  logic [1:0]        mode,
  input  logic [TEMP_W-1:0] heat_sp,
  input  logic [TEMP_W-1:0] cool_sp,
  output logic              heater,
  output logic              airConditioner,
  output logic [1:0]        fan_speed,
  output logic [1:0]        state,
  output logic              occupied
);

  localparam int unsigned CW = TEMP_W + 1;
  localparam int unsigned DW = $clog2(DWELL + 1);
  localparam int unsigned OW = $clog2(OCC_HOLD + 1);

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_HEAT    = 2'b01;
  localparam logic [1:0] S_COOL    = 2'b10;
  localparam logic [1:0] S_LOCKOUT = 2'b11;

  logic [OW-1:0] occ_cnt;
  logic [DW-1:0] dwell_cnt, dwell_next;
  logic [1:0]    state_next, fan_next;
  logic          heater_next, ac_next;
  logic [CW-1:0] t_x, hsp_x, csp_x, hyst_x;
  logic [CW-1:0] heat_err, cool_err, err, fan_q;
  logic [1:0]    fan_level;
  logic          active, heat_ok, cool_ok, heat_call, cool_call;
  logic          heat_done, cool_done, dwell_zero;

  // Widen by one bit so hysteresis additions never wrap
  assign t_x    = CW'(temperature);
  assign hsp_x  = CW'(heat_sp);
  assign csp_x  = CW'(cool_sp);
  assign hyst_x = CW'(HYST);

  assign occupied   = humanDetector | (occ_cnt != '0);
  assign active     = occupied && (mode != 2'b00) && (hsp_x < csp_x);
  assign heat_ok    = mode[0];
  assign cool_ok    = mode[1];
  assign heat_call  = active && heat_ok && (t_x < hsp_x);
  assign cool_call  = active && cool_ok && (t_x > csp_x);
  assign heat_done  = (t_x >= hsp_x + hyst_x) || !active || !heat_ok;
  assign cool_done  = (t_x + hyst_x <= csp_x) || !active || !cool_ok;
  assign dwell_zero = (dwell_cnt == '0);

  // Occupancy hold-off timer
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_cnt <= '0;
    end else if (humanDetector) begin
      occ_cnt <= OW'(OCC_HOLD);
    end else if (occ_cnt != '0) begin
      occ_cnt <= occ_cnt - OW'(1);
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      dwell_cnt      <= '0;
      fan_speed      <= 2'b00;
      heater         <= 1'b0;
      airConditioner <= 1'b0;
    end else begin
      state          <= state_next;
      dwell_cnt      <= dwell_next;
      fan_speed      <= fan_next;
      heater         <= heater_next;
      airConditioner <= ac_next;
    end
  end

  // Next state; exits from HEAT/COOL/LOCKOUT wait for the dwell counter
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (heat_call)      state_next = S_HEAT;
        else if (cool_call) state_next = S_COOL;
      end
      S_HEAT:    if (dwell_zero && heat_done) state_next = S_LOCKOUT;
      S_COOL:    if (dwell_zero && cool_done) state_next = S_LOCKOUT;
      S_LOCKOUT: if (dwell_zero)              state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase

    dwell_next = dwell_zero ? '0 : dwell_cnt - DW'(1);
    if ((state_next != state) && (state_next != S_IDLE)) begin
      dwell_next = DW'(DWELL - 1);
    end
  end

  // Output decode from the upcoming state; fan tracks error every cycle
  always_comb begin
    heat_err    = (hsp_x > t_x) ? hsp_x - t_x : '0;
    cool_err    = (t_x > csp_x) ? t_x - csp_x : '0;
    err         = (state_next == S_COOL) ? cool_err : heat_err;
    fan_q       = err / CW'(FAN_STEP);
    fan_level   = (fan_q >= CW'(2)) ? 2'd3 : fan_q[1:0] + 2'd1;
    heater_next = (state_next == S_HEAT);
    ac_next     = (state_next == S_COOL);
    fan_next    = 2'b00;
    case (state_next)
      S_HEAT, S_COOL: fan_next = fan_level;
      S_LOCKOUT:      fan_next = 2'b01;
      default:        fan_next = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_climate_controller.sv
// Directed table plus hand sequences for climate_controller at default parameters.
module tb_climate_controller;

  logic       clk = 1'b0;
  logic       rst, humanDetector, heater, airConditioner, occupied;
  logic [6:0] temperature, heat_sp, cool_sp;
  logic [1:0] mode, fan_speed, state;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [1:0] IDL = 2'd0, HT = 2'd1, CL = 2'd2, LK = 2'd3;

  typedef struct {
    logic       rst;
    logic       hd;
    logic [1:0] mode;
    logic [6:0] temp, hsp, csp;
    logic [1:0] est, efan;
    logic       eocc;
  } vec_t;

  vec_t vt[$];

  climate_controller dut (
    .clk(clk), .rst(rst), .temperature(temperature), .humanDetector(humanDetector),
    .mode(mode), .heat_sp(heat_sp), .cool_sp(cool_sp), .heater(heater),
    .airConditioner(airConditioner), .fan_speed(fan_speed), .state(state),
    .occupied(occupied)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic h, input logic [1:0] m, input logic [6:0] t,
                     input logic [6:0] hs, input logic [6:0] cs, input logic [1:0] es,
                     input logic [1:0] ef, input logic eo);
    vec_t v;
    v.rst = r; v.hd = h; v.mode = m; v.temp = t; v.hsp = hs; v.csp = cs;
    v.est = es; v.efan = ef; v.eocc = eo;
    vt.push_back(v);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [1:0] es, input logic [1:0] ef,
                       input logic eo);
    logic eh, ea;
    eh = (es == HT);
    ea = (es == CL);
    n_vec++;
    if (state !== es || heater !== eh || airConditioner !== ea ||
        fan_speed !== ef || occupied !== eo) begin
      n_bad++;
      $display("FAIL %s: got state=%0d heater=%0b ac=%0b fan=%0d occ=%0b, want state=%0d heater=%0b ac=%0b fan=%0d occ=%0b",
               nm, state, heater, airConditioner, fan_speed, occupied, es, eh, ea, ef, eo);
    end
  endtask

  task automatic hold(input int n, input string nm, input logic [1:0] es,
                      input logic [1:0] ef, input logic eo);
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("%s_%0d", nm, i), es, ef, eo);
    end
  endtask

  initial begin
    // reset, heat dwell with fan tracking, hysteresis exit, lockout, mode/setpoint blocks
    add(1, 1, 3, 10, 20, 26, IDL, 0, 1);
    add(1, 1, 3, 10, 20, 26, IDL, 0, 1);
    add(0, 1, 3, 10, 20, 26, HT,  3, 1);
    add(0, 1, 3, 10, 20, 26, HT,  3, 1);
    add(0, 1, 3, 10, 20, 26, HT,  3, 1);
    add(0, 1, 3, 23, 20, 26, HT,  1, 1);
    add(0, 1, 3, 16, 20, 26, HT,  2, 1);
    add(0, 1, 3, 10, 20, 26, HT,  3, 1);
    add(0, 1, 3, 10, 20, 26, HT,  3, 1);
    add(0, 1, 3, 10, 20, 26, HT,  3, 1);
    add(0, 1, 3, 19, 20, 26, HT,  1, 1);
    add(0, 1, 3, 21, 20, 26, HT,  1, 1);
    for (int i = 0; i < 8; i++) add(0, 1, 3, 22, 20, 26, LK, 1, 1);
    add(0, 1, 3, 22, 20, 26, IDL, 0, 1);
    add(0, 1, 3, 22, 20, 26, IDL, 0, 1);
    add(0, 1, 1, 30, 20, 26, IDL, 0, 1);
    add(0, 1, 2, 10, 20, 26, IDL, 0, 1);
    add(0, 1, 3, 10, 26, 20, IDL, 0, 1);
    add(0, 1, 3, 30, 26, 20, IDL, 0, 1);
    add(0, 1, 3, 20, 20, 26, IDL, 0, 1);
    add(0, 1, 3, 26, 20, 26, IDL, 0, 1);

    foreach (vt[i]) begin
      rst = vt[i].rst; humanDetector = vt[i].hd; mode = vt[i].mode;
      temperature = vt[i].temp; heat_sp = vt[i].hsp; cool_sp = vt[i].csp;
      tick();
      check($sformatf("vec%0d", i), vt[i].est, vt[i].efan, vt[i].eocc);
    end

    // Dwell holds HEAT despite overshoot, then lockout, idle, and cool changeover
    temperature = 15;
    tick(); check("chg_heat_entry", HT, 2, 1);
    temperature = 30;
    hold(7, "chg_heat_dwell", HT, 1, 1);
    hold(8, "chg_lockout", LK, 1, 1);
    hold(1, "chg_idle", IDL, 0, 1);
    hold(1, "chg_cool", CL, 2, 1);

    // Occupancy hold-off with a re-assert pulse at the 10th edge
    hold(7, "occ_dwell", CL, 2, 1);
    humanDetector = 0;
    hold(9, "occ_hold_a", CL, 2, 1);
    humanDetector = 1;
    hold(1, "occ_pulse", CL, 2, 1);
    humanDetector = 0;
    hold(15, "occ_hold_b", CL, 2, 1);
    hold(1, "occ_fall", CL, 2, 0);
    hold(1, "occ_lockout", LK, 1, 0);
    hold(7, "occ_lockout_rest", LK, 1, 0);
    hold(1, "occ_idle", IDL, 0, 0);

    // Occupied follows humanDetector without waiting for an edge
    temperature = 10;
    humanDetector = 1;
    #1;
    check("occ_comb", IDL, 0, 1);

    // Mode OFF mid-heat: dwell still honoured before lockout
    hold(2, "off_heat_early", HT, 3, 1);
    mode = 2'b00;
    hold(6, "off_heat_dwell", HT, 3, 1);
    hold(8, "off_lockout", LK, 1, 1);
    hold(2, "off_idle", IDL, 0, 1);

    // Reset on the third COOL cycle drops straight to IDLE with no lockout
    mode = 2'b11;
    temperature = 30;
    hold(3, "rst_cool", CL, 2, 1);
    rst = 1;
    hold(1, "rst_mid_cool", IDL, 0, 1);
    rst = 0;
    temperature = 22;
    hold(1, "rst_after_idle", IDL, 0, 1);
    temperature = 30;
    hold(1, "rst_direct_cool", CL, 2, 1);
    rst = 1;
    humanDetector = 0;
    hold(1, "rst_clears_occ", IDL, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
